// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types, frame constants and counter sizing
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  function automatic int cnt_width(input int half_bit);
    return $clog2(2 * half_bit);
  endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial line in, received byte/strobe/framing flag out
interface uart_rx_core_if;
  logic       rxd_orig;
  logic       rx_ready;
  logic [7:0] rdata;
  logic       ferr;
  modport master (output rxd_orig, input rx_ready, rdata, ferr);
  modport slave (input rxd_orig, output rx_ready, rdata, ferr);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the async input through two flops to settle metastability
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) {q, meta} <= {RESET_VAL, RESET_VAL};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver timed by a half-bit cycle count
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_HALF_BIT = 10
) (
  input  logic           clock,
  input  logic           resetn,
  uart_rx_core_if.slave  rx
);
  localparam int CW = cnt_width(CLOCK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLOCK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_END = CW'(2 * CLOCK_PER_HALF_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n, rdata_q, rdata_n;
  logic ferr_q, ferr_n, rdy_q, rdy_n;
  logic rxs;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .resetn(resetn),
    .d     (rx.rxd_orig),
    .q     (rxs)
  );
  assign rx.rx_ready = rdy_q;
  assign rx.rdata = rdata_q;
  assign rx.ferr = ferr_q;
  // state, timing counter, shift register and registered outputs
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      rdata_q <= '0;
      ferr_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      rdata_q <= rdata_n;
      ferr_q <= ferr_n;
      rdy_q <= rdy_n;
    end
  // frame sequencing; counter restarts at every sample point so no drift accumulates
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    rdata_n = rdata_q;
    ferr_n = ferr_q;
    rdy_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == HALF_END) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_END) begin
        cnt_n = '0;
        sh_n[idx] = rxs;
        idx_n = idx + 1'b1;
        if (idx == LAST_BIT) state_n = STOP;
      end
      STOP: if (cnt == FULL_END) begin
        cnt_n = '0;
        rdata_n = sh;
        ferr_n = ~rxs;
        rdy_n = 1'b1;
        state_n = rxs ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against hand-computed bytes, flags and latency
module tb_uart_rx_core;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int cyc = 0, pulses = 0, last_cyc = 0, start_cyc = 0, p0 = 0;
  int vectors = 0, miscompares = 0;
  uart_rx_core_if ifc ();
  uart_rx_core #(.CLOCK_PER_HALF_BIT(10)) dut (
    .clock (clock),
    .resetn(resetn),
    .rx    (ifc.slave)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (ifc.rx_ready === 1'b1) begin
      pulses <= pulses + 1;
      last_cyc <= cyc;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int per);
    start_cyc = cyc;
    ifc.rxd_orig = 1'b0;
    hold(per);
    for (int i = 0; i < 8; i++) begin
      ifc.rxd_orig = d[i];
      hold(per);
    end
    ifc.rxd_orig = stop;
    hold(per);
  endtask
  initial begin
    ifc.rxd_orig = 1'b1;
    resetn = 1'b0;
    hold(3);
    check("rst_ready", {31'd0, ifc.rx_ready}, 32'd0);
    check("rst_rdata", {24'd0, ifc.rdata}, 32'h00);
    check("rst_ferr", {31'd0, ifc.ferr}, 32'd0);
    resetn = 1'b1;
    hold(500);
    check("idle_no_strobe", pulses, 0);
    send(8'h99, 1'b1, 20);
    hold(20);
    check("b99_count", pulses, 1);
    check("b99_latency", last_cyc - start_cyc, 193);
    check("b99_rdata", {24'd0, ifc.rdata}, 32'h99);
    check("b99_ferr", {31'd0, ifc.ferr}, 32'd0);
    p0 = pulses;
    send(8'hAA, 1'b1, 20);
    check("bAA_rdata", {24'd0, ifc.rdata}, 32'hAA);
    check("bAA_ferr", {31'd0, ifc.ferr}, 32'd0);
    send(8'h55, 1'b1, 20);
    hold(20);
    check("b55_rdata", {24'd0, ifc.rdata}, 32'h55);
    check("b55_ferr", {31'd0, ifc.ferr}, 32'd0);
    check("b2b_count", pulses - p0, 2);
    p0 = pulses;
    ifc.rxd_orig = 1'b0;
    hold(5);
    ifc.rxd_orig = 1'b1;
    hold(40);
    check("glitch_no_strobe", pulses - p0, 0);
    send(8'h3C, 1'b1, 20);
    hold(20);
    check("b3C_rdata", {24'd0, ifc.rdata}, 32'h3C);
    check("b3C_ferr", {31'd0, ifc.ferr}, 32'd0);
    check("b3C_count", pulses - p0, 1);
    p0 = pulses;
    send(8'hC3, 1'b0, 20);
    hold(100);
    check("brk_count", pulses - p0, 1);
    check("brk_rdata", {24'd0, ifc.rdata}, 32'hC3);
    check("brk_ferr", {31'd0, ifc.ferr}, 32'd1);
    ifc.rxd_orig = 1'b1;
    hold(40);
    send(8'h01, 1'b1, 20);
    hold(20);
    check("b01_rdata", {24'd0, ifc.rdata}, 32'h01);
    check("b01_ferr", {31'd0, ifc.ferr}, 32'd0);
    check("b01_count", pulses - p0, 2);
    p0 = pulses;
    ifc.rxd_orig = 1'b0;
    hold(20 + 4 * 20 + 10);
    resetn = 1'b0;
    #2;
    check("midrst_rdata", {24'd0, ifc.rdata}, 32'h00);
    check("midrst_ferr", {31'd0, ifc.ferr}, 32'd0);
    check("midrst_ready", {31'd0, ifc.rx_ready}, 32'd0);
    hold(5);
    ifc.rxd_orig = 1'b1;
    resetn = 1'b1;
    hold(300);
    check("midrst_no_strobe", pulses - p0, 0);
    send(8'h12, 1'b1, 19);
    hold(20);
    check("b12_fast_rdata", {24'd0, ifc.rdata}, 32'h12);
    check("b12_fast_ferr", {31'd0, ifc.ferr}, 32'd0);
    send(8'h34, 1'b1, 21);
    hold(20);
    check("b34_slow_rdata", {24'd0, ifc.rdata}, 32'h34);
    check("b34_slow_ferr", {31'd0, ifc.ferr}, 32'd0);
    check("skew_count", pulses - p0, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
